mux_bus_slave: RTL
==================

Name: mux_bus_slave

Overview:
Responder side of the 8-bit Intel-mode multiplexed AD bus (CSn/ALE/RDn/WRn/AD[7:0]), the same bus the control board drives toward the SJA1000.
- Lets an external bus master access an FPGA-internal 8-bit register space.
- Decodes bus cycles and emits single-cycle read/write strobes to a local register file.
- Drives read data back onto AD and drives an active-low interrupt line.
- Sits between the top-level tristate pads and a local register bank.

Parameters:
SYNC_STAGES, 2, synchronizer depth for CSn/ALE/RDn/WRn (min 2).
RD_LAT, 1, clocks from reg_re to valid reg_rdata (1..3).
TIMEOUT, 255, clocks allowed in ADDR state before abort (used only with MUX_BUS_TIMEOUT_EN).
U_DLY, 1, simulation delay on registered assignments.

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  asynchronous, active-low reset.
bus_csn  in  1  chip select, active low, asynchronous to clk.
bus_ale  in  1  address latch enable, active high.
bus_rdn  in  1  read strobe, active low.
bus_wrn  in  1  write strobe, active low.
bus_ad_in  in  8  AD pad input.
bus_ad_out  out  8  AD pad output data.
bus_ad_oe  out  1  AD pad output enable; the top level builds the tristate.
bus_intn  out  1  interrupt to master, active low.
reg_addr  out  8  latched register address.
reg_wdata  out  8  write data.
reg_we  out  1  one-clock write strobe.
reg_re  out  1  one-clock read strobe.
reg_rdata  in  8  read data, valid RD_LAT clocks after reg_re.
int_src  in  8  level interrupt sources, active high.
int_mask  in  8  per-source enable.
proto_err_cnt  out  8  saturating protocol-error count.

Behaviour:
- Reset values: all outputs 0 except bus_intn=1. State is IDLE and proto_err_cnt=0.
- Synchronization: CSn/ALE/RDn/WRn pass through SYNC_STAGES flops.
  - bus_ad_in passes through SYNC_STAGES+1 flops, so sampled data lags its control edge by exactly one clock.
  - Edges are detected on the synced signals.
- IDLE -> ADDR: on a synced ALE falling edge with synced CSn=0. reg_addr <= delayed AD.
- ADDR, read branch: on a synced RDn falling edge with WRn=1, pulse reg_re for 1 clk and go to READ.
- ADDR, write branch: on a synced WRn falling edge with RDn=1, go to WRITE.
- ADDR, abort: CSn=1 aborts to IDLE without error.
- ADDR, ALE re-asserted: relatch the address on its falling edge and stay in ADDR.
- READ: wait RD_LAT clocks, register bus_ad_out <= reg_rdata, go to DRIVE.
- DRIVE:
  - bus_ad_oe = drive_q & ~bus_rdn & ~bus_csn, using the raw pad inputs so the bus is released with zero clock latency.
  - Leave to IDLE on a synced RDn rising edge or on CSn=1.
  - bus_ad_out holds its value until the next read.
- WRITE:
  - On a synced WRn rising edge: reg_wdata <= delayed AD and pulse reg_we for 1 clk, then go to IDLE.
  - CSn=1 before that rising edge: go to IDLE with no reg_we and increment proto_err_cnt.
- Protocol error: synced RDn and WRn low together in any state. Increment proto_err_cnt (saturates at 255), issue no strobe, and enter IDLE once both strobes are high.
- reg_we and reg_re are never asserted in the same clock, and each cycle produces at most one strobe.
- bus_intn is registered: ~|(int_src & int_mask), one clock of latency.
- Master timing requirement: strobe width and AD setup ≥ SYNC_STAGES+RD_LAT+2 clocks. Read data is guaranteed only after this.
- Reset mid-cycle: bus_ad_oe drops immediately (asynchronous), the FSM returns to IDLE, and the cycle is lost.

Optional Feature:
MUX_BUS_TIMEOUT_EN
- Defined: an 8-bit counter runs while the FSM is in ADDR. When it reaches TIMEOUT, return to IDLE and increment proto_err_cnt.
- Undefined: no counter; ADDR waits indefinitely for a strobe or for CSn=1.

Decomposition:
- Package mux_bus_pkg holds:
  - FSM state encodings IDLE/ADDR/READ/DRIVE/WRITE;
  - AD_W=8 and ADDR_W=8;
  - the error-counter width.
- Sub-module mux_bus_sync: N-stage synchronizer with rise/fall pulse outputs, instantiated once per control line.

Test Plan:
- Write 0x23 <- 0x5A: exactly one reg_we, with reg_addr=0x23 and reg_wdata=0x5A. No reg_re and bus_ad_oe stays 0.
- Read 0x84 with reg_rdata=0xC3 and RD_LAT=1: exactly one reg_re. bus_ad_out=0xC3 while RDn is low, and bus_ad_oe falls in the same delta as the raw RDn rising.
- RDn and WRn both low: proto_err_cnt goes 0->1 with no strobes. 300 repeats saturate the count at 255.
- ALE pulsed twice with 0x10 then 0x11, then a write of 0x77: a single reg_we with reg_addr=0x11.
- MUX_BUS_TIMEOUT_EN with TIMEOUT=255: ALE with no strobe for 256 clocks returns the FSM to IDLE and proto_err_cnt=1. A later valid read succeeds.
- int_src=0x04, int_mask=0x04: bus_intn=0 one clock later. Setting the mask to 0x00 restores bus_intn=1. Asserting rst_n during DRIVE drops bus_ad_oe immediately.

Source files
------------

// File: rtl/mux_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_bus_pkg : shared widths, FSM encodings and helpers for the     |
// |               multiplexed AD bus responder.                        |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package mux_bus_pkg;

  localparam int AD_W   = 8;
  localparam int ADDR_W = 8;
  localparam int ERR_W  = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRIVE = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_bus_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_bus_sync : STAGES-deep synchronizer with single-clock rise and |
// |                fall pulses taken on the synchronized level.        |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module mux_bus_sync
  import mux_bus_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule
`default_nettype wire

// File: rtl/mux_bus_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_bus_slave : Intel-mode multiplexed AD bus responder driving a  |
// |                 local register bank. Option: MUX_BUS_TIMEOUT_EN    |
// |                 aborts a stalled address phase after TIMEOUT clks. |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module mux_bus_slave
  import mux_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT     = 255,
  parameter int U_DLY       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_csn,
  input  logic              bus_ale,
  input  logic              bus_rdn,
  input  logic              bus_wrn,
  input  logic [AD_W-1:0]   bus_ad_in,
  output logic [AD_W-1:0]   bus_ad_out,
  output logic              bus_ad_oe,
  output logic              bus_intn,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [AD_W-1:0]   reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [AD_W-1:0]   reg_rdata,
  input  logic [7:0]        int_src,
  input  logic [7:0]        int_mask,
  output logic [ERR_W-1:0]  proto_err_cnt
);

  if (SYNC_STAGES < 2 || RD_LAT < 1 || RD_LAT > 3 || TIMEOUT < 1 || TIMEOUT > 255 || U_DLY < 0)
  begin : g_bad_params
    $error("mux_bus_slave: parameter out of range");
  end

  localparam logic [1:0] c_rd_lat = 2'(RD_LAT);

  logic w_cs, w_cs_rise, w_cs_fall;
  logic w_ale, w_ale_rise, w_ale_fall;
  logic w_rd, w_rd_rise, w_rd_fall;
  logic w_wr, w_wr_rise, w_wr_fall;

  mux_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst_n(rst_n), .d(bus_csn), .q(w_cs), .rise(w_cs_rise), .fall(w_cs_fall));
  mux_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ale (
    .clk(clk), .rst_n(rst_n), .d(bus_ale), .q(w_ale), .rise(w_ale_rise), .fall(w_ale_fall));
  mux_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rdn (
    .clk(clk), .rst_n(rst_n), .d(bus_rdn), .q(w_rd), .rise(w_rd_rise), .fall(w_rd_fall));
  mux_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wrn (
    .clk(clk), .rst_n(rst_n), .d(bus_wrn), .q(w_wr), .rise(w_wr_rise), .fall(w_wr_fall));

  logic w_unused_ok;
  assign w_unused_ok = ^{w_cs_rise, w_cs_fall, w_ale, w_ale_rise};

  // One extra stage so sampled AD is one clock older than the control edge.
  logic [AD_W-1:0] ad_pipe_q [SYNC_STAGES+1];
  logic [AD_W-1:0] ad_pipe_d [SYNC_STAGES+1];
  logic [AD_W-1:0] w_ad_dly;

  always_comb begin
    ad_pipe_d[0] = bus_ad_in;
    for (int i = 1; i <= SYNC_STAGES; i++) ad_pipe_d[i] = ad_pipe_q[i-1];
  end

  assign w_ad_dly = ad_pipe_q[SYNC_STAGES];

  logic [2:0] state_q, state_d;
  logic       err_q, err_d, err_inc;
  logic       w_both_low;
  logic [1:0] rd_cnt_q, rd_cnt_d;

`ifdef MUX_BUS_TIMEOUT_EN
  localparam logic [7:0] c_timeout = 8'(TIMEOUT);
  logic [7:0] tmo_q, tmo_d;
`endif

  assign w_both_low = ~w_rd & ~w_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    err_inc = 1'b0;
    if (w_both_low) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      err_inc = ~err_q;
    end else if (err_q) begin
      state_d = ST_IDLE;
      if (w_rd && w_wr) err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  if (w_ale_fall && !w_cs) state_d = ST_ADDR;
        ST_ADDR: begin
          if (w_cs)                    state_d = ST_IDLE;
          else if (w_rd_fall && w_wr)  state_d = ST_READ;
          else if (w_wr_fall && w_rd)  state_d = ST_WRITE;
`ifdef MUX_BUS_TIMEOUT_EN
          else if (tmo_q == c_timeout) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
          end
`endif
        end
        ST_READ: begin
          if (w_cs)                         state_d = ST_IDLE;
          else if (rd_cnt_q == c_rd_lat)    state_d = ST_DRIVE;
        end
        ST_DRIVE: if (w_rd_rise || w_cs) state_d = ST_IDLE;
        ST_WRITE: begin
          if (w_wr_rise) state_d = ST_IDLE;
          else if (w_cs) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [AD_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic [AD_W-1:0]   bus_ad_out_q, bus_ad_out_d;
  logic              drive_q, drive_d;
  logic [ERR_W-1:0]  proto_err_cnt_q, proto_err_cnt_d;
  logic              intn_q, intn_d;

  always_comb begin
    reg_addr_d      = (w_ale_fall && state_d == ST_ADDR) ? w_ad_dly : reg_addr_q;
    reg_re_d        = (state_q == ST_ADDR) && (state_d == ST_READ);
    reg_we_d        = (state_q == ST_WRITE) && w_wr_rise && !w_both_low;
    reg_wdata_d     = reg_we_d ? w_ad_dly : reg_wdata_q;
    rd_cnt_d        = (state_q == ST_READ) ? rd_cnt_q + 2'd1 : 2'd0;
    bus_ad_out_d    = (state_q == ST_READ && state_d == ST_DRIVE) ? reg_rdata : bus_ad_out_q;
    drive_d         = (state_d == ST_DRIVE);
    proto_err_cnt_d = err_inc ? sat_inc(proto_err_cnt_q) : proto_err_cnt_q;
    intn_d          = ~|(int_src & int_mask);
`ifdef MUX_BUS_TIMEOUT_EN
    tmo_d           = (state_q == ST_ADDR && state_d == ST_ADDR) ? tmo_q + 8'd1 : 8'd0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= SYNC_STAGES; i++) ad_pipe_q[i] <= '0;
      reg_addr_q      <= '0;
      reg_wdata_q     <= '0;
      reg_we_q        <= 1'b0;
      reg_re_q        <= 1'b0;
      rd_cnt_q        <= 2'd0;
      bus_ad_out_q    <= '0;
      drive_q         <= 1'b0;
      proto_err_cnt_q <= '0;
      intn_q          <= 1'b1;
`ifdef MUX_BUS_TIMEOUT_EN
      tmo_q           <= 8'd0;
`endif
    end else begin
      ad_pipe_q       <= ad_pipe_d;
      reg_addr_q      <= reg_addr_d;
      reg_wdata_q     <= reg_wdata_d;
      reg_we_q        <= reg_we_d;
      reg_re_q        <= reg_re_d;
      rd_cnt_q        <= rd_cnt_d;
      bus_ad_out_q    <= bus_ad_out_d;
      drive_q         <= drive_d;
      proto_err_cnt_q <= proto_err_cnt_d;
      intn_q          <= intn_d;
`ifdef MUX_BUS_TIMEOUT_EN
      tmo_q           <= tmo_d;
`endif
    end
  end

  // Raw pad strobes gate the enable so the bus is released without clock latency.
  assign bus_ad_oe     = drive_q & ~bus_rdn & ~bus_csn;
  assign bus_ad_out    = bus_ad_out_q;
  assign bus_intn      = intn_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_we        = reg_we_q;
  assign reg_re        = reg_re_q;
  assign proto_err_cnt = proto_err_cnt_q;

endmodule
`default_nettype wire
